// File: rtl/s1_fluxo_pontos_if.sv
// Command/status interface between the S1 game control FSM (master) and the
// scoring datapath (slave).
interface s1_fluxo_pontos_if #(
    parameter int LMT_W = 4,
    parameter int ERR_W = 4,
    parameter int PTS_W = 7
);
    logic             zeraL;
    logic             contaL;
    logic             zeraErro;
    logic             contaErro;
    logic             regErro;
    logic             zeraMemErro;
    logic             zeraPontos;
    logic             regPontos;
    logic             fimL;
    logic [LMT_W-1:0] limite;
    logic [ERR_W-1:0] erros_rodada;
    logic [ERR_W-1:0] erro_lido;
    logic [PTS_W-1:0] pontos;
    logic             db_saturou;

    modport master (
        output zeraL, contaL, zeraErro, contaErro, regErro, zeraMemErro,
               zeraPontos, regPontos,
        input  fimL, limite, erros_rodada, erro_lido, pontos, db_saturou
    );

    modport slave (
        input  zeraL, contaL, zeraErro, contaErro, regErro, zeraMemErro,
               zeraPontos, regPontos,
        output fimL, limite, erros_rodada, erro_lido, pontos, db_saturou
    );
endinterface

// File: rtl/s1_fluxo_pontos.sv
// Scoring datapath for the S1 game: round counter, per-round error counter,
// error memory with registered read, and the score register.
module s1_fluxo_pontos #(
    parameter int N_RODADAS  = 16,
    parameter int LMT_W      = 4,
    parameter int ERR_W      = 4,
    parameter int PTS_W      = 7,
    parameter int PONTOS_INI = 100,
    parameter int PENALIDADE = 2
) (
    input logic              clock,
    input logic              reset,
    s1_fluxo_pontos_if.slave bus
);
    localparam int              PEN_W   = ERR_W + PTS_W;
    localparam logic [LMT_W-1:0] LMT_MAX = LMT_W'(N_RODADAS - 1);

    logic [LMT_W-1:0] cont_lmt;
    logic [ERR_W-1:0] erros;
    logic [ERR_W-1:0] mem_erro [N_RODADAS];
    logic [ERR_W-1:0] erro_lido_q;
    logic [PTS_W-1:0] pontos_q;
    logic             saturou;

    logic [PEN_W-1:0] penal;
    logic [PEN_W-1:0] pontos_ext;
    logic [PTS_W-1:0] parcial;
    logic             clamp;
    logic             sat_lmt;
    logic             sat_err;
    logic             sat_pts;

    // Penalty is formed at full width so a large error count can never wrap
    // into an apparently small deduction.
    always_comb begin
        penal      = PEN_W'(erro_lido_q) * PEN_W'(PENALIDADE);
        pontos_ext = PEN_W'(pontos_q);
        clamp      = pontos_ext < penal;
        parcial    = clamp ? '0 : PTS_W'(pontos_ext - penal);
        sat_lmt    = bus.contaL && !bus.zeraL && (cont_lmt == LMT_MAX);
        sat_err    = bus.contaErro && !bus.zeraErro && (&erros);
        sat_pts    = bus.regPontos && !bus.zeraPontos && clamp;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cont_lmt <= '0;
        end else if (bus.zeraL) begin
            cont_lmt <= '0;
        end else if (bus.contaL && (cont_lmt != LMT_MAX)) begin
            cont_lmt <= cont_lmt + LMT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            erros <= '0;
        end else if (bus.zeraErro) begin
            erros <= '0;
        end else if (bus.contaErro && !(&erros)) begin
            erros <= erros + ERR_W'(1);
        end
    end

    // NOTE: the error memory is a small register array that must read as all
    // zeros straight out of reset, so every entry sits on the async reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_RODADAS; i++) mem_erro[i] <= '0;
        end else if (bus.zeraMemErro) begin
            for (int i = 0; i < N_RODADAS; i++) mem_erro[i] <= '0;
        end else if (bus.regErro) begin
            mem_erro[cont_lmt] <= erros;
        end
    end

    // NOTE: non-blocking assignment makes this read see the pre-edge entry,
    // giving read-before-write when regErro targets the same address.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            erro_lido_q <= '0;
        end else begin
            erro_lido_q <= mem_erro[cont_lmt];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pontos_q <= '0;
        end else if (bus.zeraPontos) begin
            pontos_q <= PTS_W'(PONTOS_INI);
        end else if (bus.regPontos) begin
            pontos_q <= parcial;
        end
    end

    // A saturation event in the same cycle as zeraMemErro still gets recorded.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            saturou <= 1'b0;
        end else if (sat_lmt || sat_err || sat_pts) begin
            saturou <= 1'b1;
        end else if (bus.zeraMemErro) begin
            saturou <= 1'b0;
        end
    end

    assign bus.fimL         = (cont_lmt == LMT_MAX);
    assign bus.limite       = cont_lmt;
    assign bus.erros_rodada = erros;
    assign bus.erro_lido    = erro_lido_q;
    assign bus.pontos       = pontos_q;
    assign bus.db_saturou   = saturou;
endmodule

// File: tb/tb_s1_fluxo_pontos.sv
// Bench for s1_fluxo_pontos: vector table, hand sequences for the multi-cycle
// corners, and random commands against an integer reference model.
module tb_s1_fluxo_pontos;
    localparam int N     = 16;
    localparam int LMT_W = 4;
    localparam int ERR_W = 4;
    localparam int PTS_W = 7;
    localparam int INI   = 100;
    localparam int PEN_A = 2;
    localparam int PEN_B = 8;
    localparam int ERR_MAX = 15;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    s1_fluxo_pontos_if #(.LMT_W(LMT_W), .ERR_W(ERR_W), .PTS_W(PTS_W)) bus_a ();
    s1_fluxo_pontos_if #(.LMT_W(LMT_W), .ERR_W(ERR_W), .PTS_W(PTS_W)) bus_b ();

    s1_fluxo_pontos #(
        .N_RODADAS(N), .LMT_W(LMT_W), .ERR_W(ERR_W), .PTS_W(PTS_W),
        .PONTOS_INI(INI), .PENALIDADE(PEN_A)
    ) dut_a (.clock(clock), .reset(reset), .bus(bus_a));

    s1_fluxo_pontos #(
        .N_RODADAS(N), .LMT_W(LMT_W), .ERR_W(ERR_W), .PTS_W(PTS_W),
        .PONTOS_INI(INI), .PENALIDADE(PEN_B)
    ) dut_b (.clock(clock), .reset(reset), .bus(bus_b));

    typedef struct packed {
        logic zl; logic cl; logic ze; logic ce;
        logic re; logic zm; logic zp; logic rp;
    } cmd_t;

    localparam cmd_t IDLE = 8'b0000_0000;
    localparam cmd_t C_ZL = 8'b1000_0000;
    localparam cmd_t C_CL = 8'b0100_0000;
    localparam cmd_t C_ZE = 8'b0010_0000;
    localparam cmd_t C_CE = 8'b0001_0000;
    localparam cmd_t C_RE = 8'b0000_1000;
    localparam cmd_t C_ZM = 8'b0000_0100;
    localparam cmd_t C_ZP = 8'b0000_0010;
    localparam cmd_t C_RP = 8'b0000_0001;

    // Expected values of -1 are not checked for that row.
    typedef struct {
        cmd_t c;
        int   lmt;
        int   fim;
        int   err;
        int   lido;
        int   sat;
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int m_lmt, m_err, m_lido, m_pts, m_sat;
    int m_mem[N];

    function automatic void add(cmd_t c, int lmt, int fim, int err, int lido, int sat);
        vec_t v;
        v.c = c; v.lmt = lmt; v.fim = fim; v.err = err; v.lido = lido; v.sat = sat;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_opt(input string name, input int act, input int exp);
        if (exp >= 0) check(name, act, exp);
    endtask

    task automatic drive(input cmd_t c);
        bus_a.zeraL = c.zl;  bus_a.contaL = c.cl;
        bus_a.zeraErro = c.ze; bus_a.contaErro = c.ce;
        bus_a.regErro = c.re; bus_a.zeraMemErro = c.zm;
        bus_a.zeraPontos = c.zp; bus_a.regPontos = c.rp;
        bus_b.zeraL = c.zl;  bus_b.contaL = c.cl;
        bus_b.zeraErro = c.ze; bus_b.contaErro = c.ce;
        bus_b.regErro = c.re; bus_b.zeraMemErro = c.zm;
        bus_b.zeraPontos = c.zp; bus_b.regPontos = c.rp;
    endtask

    task automatic model_reset();
        m_lmt = 0; m_err = 0; m_lido = 0; m_pts = 0; m_sat = 0;
        foreach (m_mem[i]) m_mem[i] = 0;
    endtask

    // Reference behaviour for the PENALIDADE=2 instance, all from pre-edge state.
    task automatic model_step(input cmd_t c);
        int lido_n;
        int pen;
        int event_sat;
        lido_n    = m_mem[m_lmt];
        pen       = m_lido * PEN_A;
        event_sat = 0;
        if (c.cl && !c.zl && m_lmt == N - 1) event_sat = 1;
        if (c.ce && !c.ze && m_err == ERR_MAX) event_sat = 1;
        if (c.rp && !c.zp && m_pts < pen) event_sat = 1;
        if (c.zm) foreach (m_mem[i]) m_mem[i] = 0;
        else if (c.re) m_mem[m_lmt] = m_err;
        if (c.zl) m_lmt = 0;
        else if (c.cl && m_lmt < N - 1) m_lmt = m_lmt + 1;
        if (c.ze) m_err = 0;
        else if (c.ce && m_err < ERR_MAX) m_err = m_err + 1;
        if (c.zp) m_pts = INI;
        else if (c.rp) m_pts = (m_pts >= pen) ? m_pts - pen : 0;
        if (event_sat) m_sat = 1;
        else if (c.zm) m_sat = 0;
        m_lido = lido_n;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".limite"},       int'(bus_a.limite),       m_lmt);
        check({tag, ".fimL"},         int'(bus_a.fimL),         (m_lmt == N - 1) ? 1 : 0);
        check({tag, ".erros_rodada"}, int'(bus_a.erros_rodada), m_err);
        check({tag, ".erro_lido"},    int'(bus_a.erro_lido),    m_lido);
        check({tag, ".pontos"},       int'(bus_a.pontos),       m_pts);
        check({tag, ".db_saturou"},   int'(bus_a.db_saturou),   m_sat);
    endtask

    task automatic tick(input cmd_t c);
        @(negedge clock);
        drive(c);
        @(posedge clock);
        model_step(c);
        #1;
    endtask

    task automatic hard_reset(input string tag);
        @(negedge clock);
        drive(IDLE);
        reset = 1'b0;
        #1;
        model_reset();
        check_model(tag);
        check({tag, ".b_pontos"}, int'(bus_b.pontos), 0);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_pts;
        cmd_t c;

        // Table: round counter limits, then two rounds of error recording.
        add(C_ZL, 0, 0, 0, -1, 0);
        for (int i = 1; i <= N - 1; i++) add(C_CL, i, (i == N - 1) ? 1 : 0, 0, -1, 0);
        add(C_CL, N - 1, 1, 0, -1, 1);
        add(C_ZL | C_CL, 0, 0, 0, -1, 1);
        add(C_CE, 0, 0, 1, -1, -1);
        add(C_CE, 0, 0, 2, -1, -1);
        add(C_CE, 0, 0, 3, -1, -1);
        add(C_RE, 0, 0, 3, -1, -1);
        add(C_CL, 1, 0, 3, -1, -1);
        add(C_ZE, 1, 0, 0, -1, -1);
        add(C_CE, 1, 0, 1, -1, -1);
        add(C_RE, 1, 0, 1, -1, -1);
        add(C_ZL, 0, 0, 1, -1, -1);
        add(IDLE, 0, 0, 1, 3, -1);
        add(C_CL, 1, 0, 1, -1, -1);
        add(IDLE, 1, 0, 1, 1, -1);

        // Reset state with every command idle.
        model_reset();
        drive(IDLE);
        #12;
        check_model("por");
        reset = 1'b1;

        // Reset asserted mid-sequence takes effect without a clock edge.
        repeat (10) tick(C_CE);
        tick(C_RE);
        tick(C_ZP);
        tick(IDLE);
        tick(C_RP);
        check("mid.pontos80", int'(bus_a.pontos), 80);
        repeat (5) tick(C_CL);
        check("mid.limite5", int'(bus_a.limite), 5);
        check_model("mid");
        #2;
        reset = 1'b0;
        #1;
        check("async.limite", int'(bus_a.limite), 0);
        check("async.pontos", int'(bus_a.pontos), 0);
        check("async.erros",  int'(bus_a.erros_rodada), 0);
        check("async.lido",   int'(bus_a.erro_lido), 0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].c);
            check_model($sformatf("tbl%0d", i));
            check_opt($sformatf("tbl%0d.limite", i), int'(bus_a.limite), tbl[i].lmt);
            check_opt($sformatf("tbl%0d.fimL", i), int'(bus_a.fimL), tbl[i].fim);
            check_opt($sformatf("tbl%0d.erros", i), int'(bus_a.erros_rodada), tbl[i].err);
            check_opt($sformatf("tbl%0d.lido", i), int'(bus_a.erro_lido), tbl[i].lido);
            check_opt($sformatf("tbl%0d.sat", i), int'(bus_a.db_saturou), tbl[i].sat);
        end

        // Full FSM scoring pass over MemErro = {3,1,0,...}.
        tick(C_ZL | C_ZP);
        check("score.ini", int'(bus_a.pontos), INI);
        for (int r = 0; r < N; r++) begin
            tick(IDLE);
            check_model($sformatf("calc%0d", r));
            if (r == N - 1) check("score.fim_at_last", int'(bus_a.fimL), 1);
            tick(C_RP);
            exp_pts = (r == 0) ? 94 : 92;
            check($sformatf("score.salva%0d", r), int'(bus_a.pontos), exp_pts);
            check_model($sformatf("salva%0d", r));
            tick(C_CL);
        end

        // Penalty larger than the score clamps to zero (PENALIDADE=8 instance).
        hard_reset("rst5");
        repeat (ERR_MAX) tick(C_CE);
        tick(C_RE);
        tick(C_ZP);
        tick(IDLE);
        check("clamp.b_lido", int'(bus_b.erro_lido), 15);
        tick(C_RP);
        check("clamp.b_pontos", int'(bus_b.pontos), 0);
        check("clamp.b_sat", int'(bus_b.db_saturou), 1);
        check_model("clamp.a");
        tick(C_ZP | C_RP);
        check("clamp.b_zp_prio", int'(bus_b.pontos), INI);
        check("clamp.a_zp_prio", int'(bus_a.pontos), INI);

        // zeraMemErro over regErro, then read-before-write on the same entry.
        hard_reset("rst6");
        repeat (4) tick(C_CE);
        tick(C_RE | C_ZM);
        tick(IDLE);
        check("zm_prio.lido", int'(bus_a.erro_lido), 0);
        repeat (3) tick(C_CE);
        tick(C_CL);
        tick(C_CL);
        tick(IDLE);
        tick(C_RE);
        check("rbw.old", int'(bus_a.erro_lido), 0);
        tick(IDLE);
        check("rbw.new", int'(bus_a.erro_lido), 7);
        check_model("rbw");

        // Random commands against the reference model.
        hard_reset("rst_rnd");
        for (int i = 0; i < 400; i++) begin
            c    = cmd_t'($urandom_range(0, 255));
            c.zl = ($urandom_range(0, 7) == 0);
            c.ze = ($urandom_range(0, 5) == 0);
            c.zm = ($urandom_range(0, 15) == 0);
            c.zp = ($urandom_range(0, 9) == 0);
            if (c.zm) begin
                c.cl = 1'b0; c.ce = 1'b0; c.rp = 1'b0;
            end
            if (c.zp) c.rp = 1'b0;
            tick(c);
            check_model($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
